// File: rtl/ahb_master_arbiter_pkg.sv
// Shared types and constants for the two-port AHB-Lite master arbiter.
package ahb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    // One-hot mask selecting the port indexed by p.
    function automatic logic [1:0] port_mask(input logic p);
        port_mask = p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ahb_rr_grant.sv
// Pure two-way grant decision: round-robin on contention when RR_EN is set,
// otherwise port 0 has fixed priority.
module ahb_rr_grant #(
    parameter int RR_EN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    localparam bit RR_ON = (RR_EN != 0);

    // Choose the winning port index from the current request vector.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = RR_ON ? ~last_grant : 1'b0;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-requester arbiter sequencing one non-pipelined AHB-Lite single
// transfer at a time on a shared master port.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            wen,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [5:0]            size,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic [ADDR_W-1:0]     haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [DATA_W-1:0]     hwdata,
    input  logic [DATA_W-1:0]     hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    arb_state_t          state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                sel_s;
    logic                complete_s;

    ahb_rr_grant #(
        .RR_EN (RR_EN)
    ) u_grant (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (sel_s)
    );

    // Next-state, request capture and registered bus-control values.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d      = ARB_ADDR;
                    grant_d      = sel_s;
                    last_grant_d = sel_s;
                    addr_d       = sel_s ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                    wen_d        = sel_s ? wen[1] : wen[0];
                    size_d       = sel_s ? size[5:3] : size[2:0];
                    wdata_d      = sel_s ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (hready) begin
                    state_d = ARB_DATA;
                end else begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                // An ERROR response's first cycle has hready low, so it simply waits here.
                if (hready) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_DATA;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (state_d == ARB_ADDR) begin
            htrans_d = HTRANS_NONSEQ;
        end else begin
            htrans_d = HTRANS_IDLE;
        end

        if (state_d == ARB_DATA) begin
            hwdata_d = wdata_d;
        end else begin
            hwdata_d = {DATA_W{1'b0}};
        end
    end

    // State and captured-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= {ADDR_W{1'b0}};
            wen_q        <= 1'b0;
            size_q       <= 3'd0;
            wdata_q      <= {DATA_W{1'b0}};
            htrans_q     <= HTRANS_IDLE;
            hwdata_q     <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            htrans_q     <= htrans_d;
            hwdata_q     <= hwdata_d;
        end
    end

    // Completion is same-cycle with hready; suppressed while reset is held.
    always_comb begin
        complete_s = (state_q == ARB_DATA) && hready && !rst;
        if (complete_s) begin
            done  = port_mask(grant_q);
            err   = hresp ? port_mask(grant_q) : 2'b00;
            rdata = hrdata;
        end else begin
            done  = 2'b00;
            err   = 2'b00;
            rdata = {DATA_W{1'b0}};
        end
    end

    // Bus outputs are forced to idle values for the whole reset cycle.
    always_comb begin
        if (rst) begin
            htrans = HTRANS_IDLE;
            haddr  = {ADDR_W{1'b0}};
            hwrite = 1'b0;
            hsize  = HSIZE_BYTE;
            hwdata = {DATA_W{1'b0}};
        end else begin
            htrans = htrans_q;
            haddr  = addr_q;
            hwrite = wen_q;
            hsize  = size_q;
            hwdata = hwdata_q;
        end
    end

    assign hburst = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share stimulus.
module tb_ahb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wen;
    logic [63:0] addr, wdata;
    logic [5:0]  size;
    logic [31:0] hrdata;
    logic        hready, hresp;

    logic [31:0] rdata, haddr, hwdata;
    logic [1:0]  done, err, htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;

    logic [31:0] fp_rdata, fp_haddr, fp_hwdata;
    logic [1:0]  fp_done, fp_err, fp_htrans;
    logic        fp_hwrite;
    logic [2:0]  fp_hsize, fp_hburst;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .size(size), .rdata(rdata), .done(done), .err(err), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .size(size), .rdata(fp_rdata), .done(fp_done), .err(fp_err), .haddr(fp_haddr),
        .htrans(fp_htrans), .hwrite(fp_hwrite), .hsize(fp_hsize), .hburst(fp_hburst),
        .hwdata(fp_hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; wen = 2'b00; addr = 64'd0; wdata = 64'd0;
        size = 6'd0; hrdata = 32'hFFFF_FFFF; hready = 1'b1; hresp = 1'b0;
        step(); step(); settle();
        chk("rst_during_htrans", {62'd0, htrans}, 64'd0);
        chk("rst_during_done", {62'd0, done}, 64'd0);
        rst = 1'b0;
        step(); settle();
        chk("rst_htrans", {62'd0, htrans}, 64'd0);
        chk("rst_haddr", {32'd0, haddr}, 64'd0);
        chk("rst_hwrite", {63'd0, hwrite}, 64'd0);
        chk("rst_hsize", {61'd0, hsize}, 64'd0);
        chk("rst_hwdata", {32'd0, hwdata}, 64'd0);
        chk("rst_done", {62'd0, done}, 64'd0);
        chk("rst_err", {62'd0, err}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("hburst", {61'd0, hburst}, 64'd0);

        // Port 0 zero-wait read
        req = 2'b01; wen = 2'b00; addr[31:0] = 32'h0000_0010; size[2:0] = 3'd2;
        hrdata = 32'hDEAD_BEEF; settle();
        chk("t1_c0_htrans", {62'd0, htrans}, 64'd0);
        step(); settle();
        chk("t1_c1_htrans", {62'd0, htrans}, 64'd2);
        chk("t1_c1_haddr", {32'd0, haddr}, 64'h10);
        chk("t1_c1_hwrite", {63'd0, hwrite}, 64'd0);
        chk("t1_c1_hsize", {61'd0, hsize}, 64'd2);
        chk("t1_c1_done", {62'd0, done}, 64'd0);
        step(); settle();
        chk("t1_c2_done", {62'd0, done}, 64'd1);
        chk("t1_c2_rdata", {32'd0, rdata}, 64'hDEAD_BEEF);
        chk("t1_c2_err", {62'd0, err}, 64'd0);
        chk("t1_c2_htrans", {62'd0, htrans}, 64'd0);
        req = 2'b00;
        step(); settle();
        chk("t1_c3_done", {62'd0, done}, 64'd0);
        chk("t1_c3_rdata", {32'd0, rdata}, 64'd0);

        // Contention: reset so last_grant is 1 again
        rst = 1'b1; step(); rst = 1'b0;
        req = 2'b11; addr = {32'h0000_0200, 32'h0000_0100}; size = {3'd2, 3'd2};
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t2_idle_htrans", {62'd0, htrans}, 64'd0);
            chk("t2_idle_done", {62'd0, done}, 64'd0);
            step(); settle();
            chk("t2_rr_haddr", {32'd0, haddr}, (k % 2 == 1) ? 64'h200 : 64'h100);
            chk("t2_fp_haddr", {32'd0, fp_haddr}, 64'h100);
            step(); settle();
            chk("t2_rr_done", {62'd0, done}, (k % 2 == 1) ? 64'd2 : 64'd1);
            chk("t2_fp_done", {62'd0, fp_done}, 64'd1);
            if (k == 3) req = 2'b00;
            step();
        end

        // Port 1 write with three DATA wait states
        req = 2'b10; wen = 2'b10; addr[63:32] = 32'h0002_0004;
        wdata[63:32] = 32'h1234_5678; size[5:3] = 3'd2; settle();
        step(); settle();
        chk("t3_addr_htrans", {62'd0, htrans}, 64'd2);
        chk("t3_addr_haddr", {32'd0, haddr}, 64'h0002_0004);
        chk("t3_addr_hwrite", {63'd0, hwrite}, 64'd1);
        step(); hready = 1'b0;
        wdata[63:32] = 32'd0; addr[63:32] = 32'hFFFF_0000; wen = 2'b00;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("t3_wait_done", {62'd0, done}, 64'd0);
            chk("t3_wait_hwdata", {32'd0, hwdata}, 64'h1234_5678);
            chk("t3_wait_haddr", {32'd0, haddr}, 64'h0002_0004);
            chk("t3_wait_hwrite", {63'd0, hwrite}, 64'd1);
            chk("t3_wait_htrans", {62'd0, htrans}, 64'd0);
            if (i < 2) begin
                step(); settle();
            end
        end
        step(); hready = 1'b1; settle();
        chk("t3_done", {62'd0, done}, 64'd2);
        chk("t3_fp_done", {62'd0, fp_done}, 64'd2);
        chk("t3_done_hwdata", {32'd0, hwdata}, 64'h1234_5678);
        chk("t3_err", {62'd0, err}, 64'd0);
        req = 2'b00;
        step(); settle();
        chk("t3_idle_hwdata", {32'd0, hwdata}, 64'd0);
        chk("t3_idle_done", {62'd0, done}, 64'd0);

        // Port 0 read with two-cycle ERROR response
        req = 2'b01; addr[31:0] = 32'h0003_0000; settle();
        step(); settle();
        chk("t4_addr_haddr", {32'd0, haddr}, 64'h0003_0000);
        step(); hready = 1'b0; hresp = 1'b1; settle();
        chk("t4_err1_done", {62'd0, done}, 64'd0);
        chk("t4_err1_err", {62'd0, err}, 64'd0);
        chk("t4_err1_htrans", {62'd0, htrans}, 64'd0);
        step(); hready = 1'b1; settle();
        chk("t4_err2_done", {62'd0, done}, 64'd1);
        chk("t4_err2_err", {62'd0, err}, 64'd1);
        chk("t4_err2_htrans", {62'd0, htrans}, 64'd0);
        req = 2'b00;
        step(); hresp = 1'b0; settle();
        chk("t4_after_err", {62'd0, err}, 64'd0);

        // Reset while a transfer is stalled in DATA
        req = 2'b01; addr = {32'h0000_0050, 32'h0000_0040}; settle();
        step(); settle();
        step(); hready = 1'b0; settle();
        chk("t5_stall_done", {62'd0, done}, 64'd0);
        rst = 1'b1; hready = 1'b1; req = 2'b10; settle();
        chk("t5_rst_done", {62'd0, done}, 64'd0);
        chk("t5_rst_err", {62'd0, err}, 64'd0);
        step(); rst = 1'b0; settle();
        chk("t5_post_htrans", {62'd0, htrans}, 64'd0);
        chk("t5_post_done", {62'd0, done}, 64'd0);
        chk("t5_post_haddr", {32'd0, haddr}, 64'd0);
        step(); settle();
        chk("t5_p1_htrans", {62'd0, htrans}, 64'd2);
        chk("t5_p1_haddr", {32'd0, haddr}, 64'h50);
        step(); settle();
        chk("t5_p1_done", {62'd0, done}, 64'd2);
        req = 2'b00;
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
